// File: rtl/rv_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rv_fetch_ctrl
// Purpose  : Instruction fetch sequencer for the halfword fetch buffer.
//            Issues word-aligned instruction bus requests (one outstanding at
//            a time) and turns each returned 32-bit word into one or two
//            halfword pushes. Handles redirects by flushing the buffer,
//            reloading its PC and discarding any data still in flight.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk          : clock, all state updates on the rising edge
//   i_reset        : asynchronous active-high reset
//   i_branch       : redirect request (one-cycle pulse)
//   i_branch_pc    : redirect target, halfword address
//   o_mem_req      : bus request, held until i_mem_ack
//   o_mem_addr     : bus word address, stable while o_mem_req=1
//   i_mem_ack      : bus completion, i_mem_data valid this cycle
//   i_mem_data     : fetched 32-bit word
//   i_buf_not_full : buffer has room for at least one more word
//   o_buf_flush    : buffer reset (buffer i_reset_n = !o_buf_flush)
//   o_buf_pc       : PC loaded into the buffer while o_buf_flush=1
//   o_push_single  : push o_data_hi only
//   o_push_double  : push o_data_lo then o_data_hi
//   o_data_lo      : lower halfword of i_mem_data
//   o_data_hi      : upper halfword of i_mem_data
// ============================================================================
module rv_fetch_ctrl #(
  parameter int unsigned                 IADDR_SPACE_BITS = 16,
  parameter logic [IADDR_SPACE_BITS-1:0] RESET_PC         = '0
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_branch,
  input  logic [IADDR_SPACE_BITS-1:1]   i_branch_pc,
  output logic                          o_mem_req,
  output logic [IADDR_SPACE_BITS-1:2]   o_mem_addr,
  input  logic                          i_mem_ack,
  input  logic [31:0]                   i_mem_data,
  input  logic                          i_buf_not_full,
  output logic                          o_buf_flush,
  output logic [IADDR_SPACE_BITS-1:1]   o_buf_pc,
  output logic                          o_push_single,
  output logic                          o_push_double,
  output logic [15:0]                   o_data_lo,
  output logic [15:0]                   o_data_hi
);

  // IDLE  : no request outstanding
  // REQ   : request outstanding, its data is wanted
  // DRAIN : request outstanding, but a redirect made its data stale
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [IADDR_SPACE_BITS-1:2] c_word_one =
    {{(IADDR_SPACE_BITS-3){1'b0}}, 1'b1};

  state_t                        state_q,      state_d;
  logic [IADDR_SPACE_BITS-1:2]   fetch_addr_q, fetch_addr_d;
  logic                          skip_lo_q,    skip_lo_d;
  logic                          mem_req_q,    mem_req_d;
  logic [IADDR_SPACE_BITS-1:2]   mem_addr_q,   mem_addr_d;
  logic                          buf_flush_q,  buf_flush_d;
  logic [IADDR_SPACE_BITS-1:1]   buf_pc_q,     buf_pc_d;

  logic                          w_ack_live;
  logic [IADDR_SPACE_BITS-1:2]   w_fetch_next;

  // An ack only delivers usable data when the request is still wanted and
  // no redirect arrives in the same cycle.
  assign w_ack_live   = (state_q == ST_REQ) && i_mem_ack && !i_branch;
  assign w_fetch_next = fetch_addr_q + c_word_one;

  // --------------------------------------------------------------------------
  // Next-state / next-register logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    skip_lo_d    = skip_lo_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    buf_flush_d  = 1'b0;
    buf_pc_d     = buf_pc_q;

    if (i_branch) begin
      // Redirect wins over everything: reload the stream start and pulse
      // the buffer flush next cycle.
      buf_flush_d  = 1'b1;
      buf_pc_d     = i_branch_pc;
      fetch_addr_d = i_branch_pc[IADDR_SPACE_BITS-1:2];
      skip_lo_d    = i_branch_pc[1];

      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_REQ, ST_DRAIN: begin
          if (i_mem_ack) begin
            // The old request completes right now; its data is dropped.
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
          end else begin
            // A bus request is never withdrawn: keep it up with the old
            // address and throw the data away when it eventually arrives.
            state_d = ST_DRAIN;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
        end
      endcase
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_buf_not_full) begin
            state_d    = ST_REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = fetch_addr_q;
          end
        end

        ST_REQ: begin
          if (i_mem_ack) begin
            fetch_addr_d = w_fetch_next;
            // Only the first word of a stream can start mid-word.
            skip_lo_d    = 1'b0;
            if (i_buf_not_full) begin
              // Back-to-back: the buffer headroom absorbs this word.
              state_d    = ST_REQ;
              mem_req_d  = 1'b1;
              mem_addr_d = w_fetch_next;
            end else begin
              state_d   = ST_IDLE;
              mem_req_d = 1'b0;
            end
          end
        end

        ST_DRAIN: begin
          if (i_mem_ack) begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
          end
        end

        default: begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      fetch_addr_q <= RESET_PC[IADDR_SPACE_BITS-1:2];
      skip_lo_q    <= RESET_PC[1];
      mem_req_q    <= 1'b0;
      mem_addr_q   <= RESET_PC[IADDR_SPACE_BITS-1:2];
      // Hold the buffer in reset with the start PC until the first edge.
      buf_flush_q  <= 1'b1;
      buf_pc_q     <= RESET_PC[IADDR_SPACE_BITS-1:1];
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      skip_lo_q    <= skip_lo_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      buf_flush_q  <= buf_flush_d;
      buf_pc_q     <= buf_pc_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_mem_req   = mem_req_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_buf_flush = buf_flush_q;
  assign o_buf_pc    = buf_pc_q;

  // The flush term is structurally redundant (a flush cycle is never spent
  // in REQ) but keeps pushes out of a buffer that is being reset.
  assign o_push_single = w_ack_live &&  skip_lo_q && !buf_flush_q;
  assign o_push_double = w_ack_live && !skip_lo_q && !buf_flush_q;

  assign o_data_lo = i_mem_data[15:0];
  assign o_data_hi = i_mem_data[31:16];

endmodule
`default_nettype wire
